uart_frame_parser: RTL and testbench
====================================

# uart_frame_parser

Downstream consumer of the UART receiver's byte stream (`rx_data`/`data_valid`). It hunts for a sync byte, then assembles length-prefixed, checksummed frames into a ping-pong payload buffer. Each good frame is published atomically to a read port and counted. Bad frames are dropped and counted, with no disturbance to the last published frame. Its counters and read port feed the board display/LED logic in the top level.

## Interface
- `MAX_LEN`, 16: maximum payload bytes per frame; legal range 1..255.
- `SYNC_BYTE`, 8'hA5: frame start marker.
- `TIMEOUT_CYCLES`, 50_000: maximum inter-byte gap inside a frame, in clk cycles (1 ms at 50 MHz).
- `clk` in 1: system clock, 50 MHz.
- `rst_n` in 1: reset, asynchronous assert, active-low. One clock; reset is asynchronous and active-low.
- `rx_data` in 8: received byte; sampled only when `rx_valid`=1.
- `rx_valid` in 1: single-cycle byte strobe from the UART receiver.
- `rd_addr` in $clog2(MAX_LEN): payload byte index into the published frame.
- `rd_data` out 8: published payload byte at `rd_addr`, 1-cycle latency.
- `frame_valid` out 1: one-cycle pulse when a good frame is published.
- `frame_len` out 8: payload length of the published frame.
- `frame_count` out 16: good frames since reset, saturating.
- `err_count` out 16: dropped frames since reset, saturating.
- `busy` out 1: 1 whenever the state is not HUNT.

## Operation
- Frame format: SYNC, LEN, LEN payload bytes, CSUM.
- A frame is good when (LEN + Σpayload + CSUM) mod 256 = 0.
- States:
  - HUNT: a byte equal to SYNC_BYTE → LEN. Any other byte is ignored and is not an error.
  - LEN: LEN > MAX_LEN → error, HUNT. LEN = 0 → CSUM. Otherwise → PAYLOAD. A SYNC_BYTE value here is taken as a length; there is no resync.
  - PAYLOAD: each byte is written to the work bank at index 0..LEN-1. After byte LEN-1 → CSUM.
  - CSUM: sum correct → publish, then HUNT. Sum incorrect → error, then HUNT.
- Running sum: 8-bit accumulator. It is cleared on SYNC, loads LEN, then adds each payload byte and CSUM. It wraps mod 256.
- Ping-pong buffer: two banks of MAX_LEN×8.
  - The write side always fills the work bank, which is the non-published one.
  - Publish on a good frame:
    - flip the published-bank select;
    - load `frame_len` with LEN;
    - pulse `frame_valid`;
    - increment `frame_count`.
  - After publish, the former published bank becomes the work bank.
- Error handling: `err_count` increments by 1 and the state returns to HUNT. The published bank, `frame_len` and `frame_count` are untouched.
- Timeout: in any state other than HUNT, a gap counter counts cycles since the last `rx_valid`.
  - When it reaches TIMEOUT_CYCLES-1 with no `rx_valid`, the frame is an error and the state returns to HUNT.
  - If `rx_valid` coincides with the expiry cycle, the byte wins: it is processed and the counter clears.
- Counters saturate at 16'hFFFF and never wrap.
- `rd_addr` ≥ `frame_len`: `rd_data` returns the stale bank contents. Consumers must respect `frame_len`.

## Timing
- Reset values:
  - outputs: `rd_data`=0, `frame_valid`=0, `frame_len`=0, `frame_count`=0, `err_count`=0, `busy`=0;
  - internal: state HUNT, published bank 0, gap counter 0.
- Bank contents are not reset.
- All outputs are registered.
- Publish latency: `frame_valid`, the new `frame_len`, and the incremented `frame_count` are all visible at the edge following the cycle in which the CSUM byte has `rx_valid`=1.
- Error latency: `err_count` updates at the edge following the error byte or the timeout expiry.
- Read port: `rd_addr` is sampled at edge N; `rd_data` is valid after edge N. It reads the bank that is published at edge N. A read sampled on the publish edge returns the old frame.
- `busy` rises with the SYNC byte (the edge after it) and falls with the return to HUNT.
- Back-to-back frames: a SYNC in the cycle immediately after publish is accepted. `rx_valid` may assert every cycle.
- Reset mid-frame: the partial frame is discarded, both counters are 0, and `frame_len` is 0.

## Structure
- Package `uart_frame_pkg`:
  - state enum `frame_state_t` (HUNT, LEN, PAYLOAD, CSUM);
  - default SYNC_BYTE constant;
  - a saturating-increment function for 16-bit counters.
- Sub-module `uart_frame_bank`: dual-bank MAX_LEN×8 storage.
  - Write port: bank select, addr, data, we.
  - Registered read port: bank select, addr.
  - Infers RAM or registers.
- Parser FSM, gap counter, checksum accumulator and counters all live in `uart_frame_parser`.

## Test plan
- Good frame A5 03 11 22 33 97 → one `frame_valid` pulse, `frame_len`=3, reads 0..2 return 11 22 33, `frame_count`=1, `err_count`=0.
- Bad checksum A5 02 01 02 00, sent after the good frame → no pulse, `err_count`=1, reads still return 11 22 33, `frame_len`=3.
- Oversize A5 11 (17 > MAX_LEN) → `err_count`+1, `busy`=0 next cycle. A following A5 01 7F 80 → `frame_len`=1, rd_data[0]=7F.
- Timeout: A5 02 01 then idle → `err_count`+1 exactly TIMEOUT_CYCLES cycles after the 01 strobe. Repeat with a byte on the expiry cycle → no error.
- Zero length plus noise: 00 FF A5 00 00 → exactly one pulse, `frame_len`=0, `err_count` unchanged.
- Reset: assert `rst_n`=0 in the middle of a PAYLOAD, with counters nonzero → all outputs 0 asynchronously. A good frame after release publishes with `frame_count`=1.

Source files
------------

// File: rtl/uart_frame_pkg.sv
// Shared types, defaults and helpers for the UART frame parser.
// Imported by the parser top and its payload bank.
package uart_frame_pkg;

    typedef enum logic [1:0] {
        HUNT    = 2'd0,
        LEN     = 2'd1,
        PAYLOAD = 2'd2,
        CSUM    = 2'd3
    } frame_state_t;

    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

    // Counters stick at all-ones so a long soak never shows a misleading wrap.
    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        if (value == 16'hFFFF) begin
            return value;
        end else begin
            return value + 16'd1;
        end
    endfunction

endpackage

// File: rtl/uart_frame_bank.sv
// Dual-bank MAX_LEN x 8 payload store: one write port and one registered read port.
// Bank contents are deliberately left unreset; only the read register resets.
module uart_frame_bank
    import uart_frame_pkg::*;
#(
    parameter int MAX_LEN = 16,
    parameter int AW      = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_wr_bank,
    input  logic [AW-1:0] i_wr_addr,
    input  logic [7:0]    i_wr_data,
    input  logic          i_we,
    input  logic          i_rd_bank,
    input  logic [AW-1:0] i_rd_addr,
    output logic [7:0]    o_rd_data
);

    logic [7:0] r_mem [0:1][0:MAX_LEN-1];

    // Payload write into the selected bank.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_wr_bank][i_wr_addr] <= i_wr_data;
        end
    end

    // Registered read from the selected bank.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_rd_data <= 8'd0;
        end else begin
            o_rd_data <= r_mem[i_rd_bank][i_rd_addr];
        end
    end

endmodule

// File: rtl/uart_frame_parser.sv
// Hunts for SYNC, assembles length-prefixed checksummed frames into a ping-pong
// buffer, publishes good frames atomically and counts good/dropped frames.
module uart_frame_parser
    import uart_frame_pkg::*;
#(
    parameter int          MAX_LEN        = 16,
    parameter logic [7:0]  SYNC_BYTE      = SYNC_BYTE_DEFAULT,
    parameter int          TIMEOUT_CYCLES = 50_000,
    localparam int         AW             = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [7:0]    i_rx_data,
    input  logic          i_rx_valid,
    input  logic [AW-1:0] i_rd_addr,
    output logic [7:0]    o_rd_data,
    output logic          o_frame_valid,
    output logic [7:0]    o_frame_len,
    output logic [15:0]   o_frame_count,
    output logic [15:0]   o_err_count,
    output logic          o_busy
);

    localparam int GW = $clog2(TIMEOUT_CYCLES + 1);

    frame_state_t r_state;
    frame_state_t w_state_next;
    logic [7:0]   r_sum;
    logic [7:0]   r_len;
    logic [7:0]   r_idx;
    logic [GW-1:0] r_gap;
    logic         r_pub_bank;
    logic [7:0]   w_sum_add;
    logic         w_timeout;
    logic         w_publish;
    logic         w_error;
    logic         w_we;

    assign w_sum_add = r_sum + i_rx_data;
    // A byte arriving on the expiry cycle wins over the timeout.
    assign w_timeout = (r_state != HUNT) && !i_rx_valid
                       && (r_gap == GW'(TIMEOUT_CYCLES - 1));

    // Parser state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= HUNT;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and per-byte control decode.
    always_comb begin
        w_state_next = r_state;
        w_publish    = 1'b0;
        w_error      = 1'b0;
        w_we         = 1'b0;
        if (w_timeout) begin
            w_error      = 1'b1;
            w_state_next = HUNT;
        end else if (i_rx_valid) begin
            case (r_state)
                HUNT: begin
                    if (i_rx_data == SYNC_BYTE) begin
                        w_state_next = LEN;
                    end else begin
                        w_state_next = HUNT;
                    end
                end
                LEN: begin
                    if (i_rx_data > 8'(MAX_LEN)) begin
                        w_error      = 1'b1;
                        w_state_next = HUNT;
                    end else if (i_rx_data == 8'd0) begin
                        w_state_next = CSUM;
                    end else begin
                        w_state_next = PAYLOAD;
                    end
                end
                PAYLOAD: begin
                    w_we = 1'b1;
                    if (r_idx == r_len - 8'd1) begin
                        w_state_next = CSUM;
                    end else begin
                        w_state_next = PAYLOAD;
                    end
                end
                CSUM: begin
                    if (w_sum_add == 8'd0) begin
                        w_publish = 1'b1;
                    end else begin
                        w_error = 1'b1;
                    end
                    w_state_next = HUNT;
                end
                default: begin
                    w_state_next = HUNT;
                end
            endcase
        end else begin
            w_state_next = r_state;
        end
    end

    // Datapath: checksum, index, gap counter, publish and counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sum         <= 8'd0;
            r_len         <= 8'd0;
            r_idx         <= 8'd0;
            r_gap         <= '0;
            r_pub_bank    <= 1'b0;
            o_frame_valid <= 1'b0;
            o_frame_len   <= 8'd0;
            o_frame_count <= 16'd0;
            o_err_count   <= 16'd0;
            o_busy        <= 1'b0;
        end else begin
            o_frame_valid <= w_publish;
            o_busy        <= (w_state_next != HUNT);
            if ((w_state_next == HUNT) || i_rx_valid) begin
                r_gap <= '0;
            end else begin
                r_gap <= r_gap + GW'(1);
            end
            if (i_rx_valid) begin
                case (r_state)
                    HUNT: begin
                        if (i_rx_data == SYNC_BYTE) begin
                            r_sum <= 8'd0;
                        end
                    end
                    LEN: begin
                        r_sum <= i_rx_data;
                        r_len <= i_rx_data;
                        r_idx <= 8'd0;
                    end
                    PAYLOAD: begin
                        r_sum <= w_sum_add;
                        r_idx <= r_idx + 8'd1;
                    end
                    default: begin
                        r_sum <= w_sum_add;
                    end
                endcase
            end
            if (w_publish) begin
                r_pub_bank    <= ~r_pub_bank;
                o_frame_len   <= r_len;
                o_frame_count <= sat_inc16(o_frame_count);
            end
            if (w_error) begin
                o_err_count <= sat_inc16(o_err_count);
            end
        end
    end

    uart_frame_bank #(
        .MAX_LEN (MAX_LEN),
        .AW      (AW)
    ) u_bank (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_wr_bank (~r_pub_bank),
        .i_wr_addr (r_idx[AW-1:0]),
        .i_wr_data (i_rx_data),
        .i_we      (w_we),
        .i_rd_bank (r_pub_bank),
        .i_rd_addr (i_rd_addr),
        .o_rd_data (o_rd_data)
    );

endmodule

// File: tb/tb_uart_frame_parser.sv
// Directed and randomized checks of uart_frame_parser against an arithmetic
// frame model (checksum by plain sums, published frame kept as an array).
module tb_uart_frame_parser;

    localparam int MAX_LEN = 16;
    localparam int TO      = 200;

    logic        clk;
    logic        rst_n;
    logic [7:0]  i_rx_data;
    logic        i_rx_valid;
    logic [3:0]  i_rd_addr;
    logic [7:0]  o_rd_data;
    logic        o_frame_valid;
    logic [7:0]  o_frame_len;
    logic [15:0] o_frame_count;
    logic [15:0] o_err_count;
    logic        o_busy;

    int n_pass  = 0;
    int n_total = 0;

    uart_frame_parser #(
        .MAX_LEN        (MAX_LEN),
        .SYNC_BYTE      (8'hA5),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_rx_data     (i_rx_data),
        .i_rx_valid    (i_rx_valid),
        .i_rd_addr     (i_rd_addr),
        .o_rd_data     (o_rd_data),
        .o_frame_valid (o_frame_valid),
        .o_frame_len   (o_frame_len),
        .o_frame_count (o_frame_count),
        .o_err_count   (o_err_count),
        .o_busy        (o_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        chk(tag, {8'h00, obs}, {8'h00, exp});
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        chk(tag, {15'd0, obs}, {15'd0, exp});
    endtask

    // Idle for gap cycles, then present one byte for exactly one cycle.
    task automatic send_byte(input logic [7:0] b, input int gap);
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        i_rx_data  = b;
        i_rx_valid = 1'b1;
        @(posedge clk);
        #1;
        i_rx_valid = 1'b0;
    endtask

    task automatic read_chk(input string tag, input int idx, input logic [7:0] exp);
        i_rd_addr = 4'(idx);
        @(posedge clk);
        #1;
        chk8(tag, o_rd_data, exp);
    endtask

    initial begin
        int         kind;
        int         len;
        int         sum;
        int         csum;
        int         idx;
        int         exp_count;
        int         exp_err;
        int         pub_len;
        logic [7:0] pl      [MAX_LEN];
        logic [7:0] pub_mem [MAX_LEN];
        logic [7:0] b;

        rst_n      = 1'b0;
        i_rx_data  = 8'd0;
        i_rx_valid = 1'b0;
        i_rd_addr  = 4'd0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        chk8("rst_rd_data", o_rd_data, 8'd0);
        chk1("rst_frame_valid", o_frame_valid, 1'b0);
        chk8("rst_frame_len", o_frame_len, 8'd0);
        chk("rst_frame_count", o_frame_count, 16'd0);
        chk("rst_err_count", o_err_count, 16'd0);
        chk1("rst_busy", o_busy, 1'b0);

        // Good frame A5 03 11 22 33 97
        send_byte(8'hA5, 0);
        chk1("busy_after_sync", o_busy, 1'b1);
        send_byte(8'h03, 0);
        send_byte(8'h11, 0);
        send_byte(8'h22, 1);
        send_byte(8'h33, 0);
        send_byte(8'h97, 2);
        chk1("good_valid", o_frame_valid, 1'b1);
        chk8("good_len", o_frame_len, 8'd3);
        chk("good_count", o_frame_count, 16'd1);
        chk("good_err", o_err_count, 16'd0);
        chk1("good_busy", o_busy, 1'b0);
        read_chk("good_rd0", 0, 8'h11);
        chk1("good_valid_pulse_end", o_frame_valid, 1'b0);
        read_chk("good_rd1", 1, 8'h22);
        read_chk("good_rd2", 2, 8'h33);

        // Bad checksum A5 02 01 02 00
        send_byte(8'hA5, 0);
        send_byte(8'h02, 0);
        send_byte(8'h01, 0);
        send_byte(8'h02, 0);
        send_byte(8'h00, 0);
        chk1("bad_valid", o_frame_valid, 1'b0);
        chk("bad_err", o_err_count, 16'd1);
        chk("bad_count", o_frame_count, 16'd1);
        chk8("bad_len", o_frame_len, 8'd3);
        read_chk("bad_rd0", 0, 8'h11);
        read_chk("bad_rd1", 1, 8'h22);
        read_chk("bad_rd2", 2, 8'h33);

        // Oversize length, then a one-byte frame
        send_byte(8'hA5, 0);
        send_byte(8'h11, 0);
        chk("over_err", o_err_count, 16'd2);
        chk1("over_busy", o_busy, 1'b0);
        send_byte(8'hA5, 0);
        send_byte(8'h01, 0);
        send_byte(8'h7F, 0);
        send_byte(8'h80, 0);
        chk1("one_valid", o_frame_valid, 1'b1);
        chk8("one_len", o_frame_len, 8'd1);
        chk("one_count", o_frame_count, 16'd2);
        read_chk("one_rd0", 0, 8'h7F);

        // Timeout: error exactly TO cycles after the last strobe
        send_byte(8'hA5, 0);
        send_byte(8'h02, 0);
        send_byte(8'h01, 0);
        repeat (TO - 1) begin
            @(posedge clk);
            #1;
        end
        chk("to_err_before", o_err_count, 16'd2);
        chk1("to_busy_before", o_busy, 1'b1);
        @(posedge clk);
        #1;
        chk("to_err_at", o_err_count, 16'd3);
        chk1("to_busy_at", o_busy, 1'b0);

        // Byte landing on the expiry cycle wins
        send_byte(8'hA5, 0);
        send_byte(8'h02, 0);
        send_byte(8'h01, 0);
        send_byte(8'h02, TO - 1);
        chk("to_win_err", o_err_count, 16'd3);
        chk1("to_win_busy", o_busy, 1'b1);
        send_byte(8'hFB, 0);
        chk1("to_win_valid", o_frame_valid, 1'b1);
        chk8("to_win_len", o_frame_len, 8'd2);
        chk("to_win_count", o_frame_count, 16'd3);
        read_chk("to_win_rd0", 0, 8'h01);
        read_chk("to_win_rd1", 1, 8'h02);

        // Zero length plus noise: 00 FF A5 00 00
        send_byte(8'h00, 0);
        send_byte(8'hFF, 0);
        chk1("noise_busy", o_busy, 1'b0);
        send_byte(8'hA5, 0);
        send_byte(8'h00, 0);
        chk1("zero_no_early_pulse", o_frame_valid, 1'b0);
        send_byte(8'h00, 0);
        chk1("zero_valid", o_frame_valid, 1'b1);
        chk8("zero_len", o_frame_len, 8'd0);
        chk("zero_count", o_frame_count, 16'd4);
        chk("zero_err", o_err_count, 16'd3);
        @(posedge clk);
        #1;
        chk1("zero_single_pulse", o_frame_valid, 1'b0);

        // Randomized frames against the arithmetic model
        exp_count = 4;
        exp_err   = 3;
        pub_len   = 0;
        for (int f = 0; f < 40; f++) begin
            repeat ($urandom_range(0, 2)) begin
                b = 8'($urandom_range(0, 255));
                if (b == 8'hA5) b = 8'h00;
                send_byte(b, $urandom_range(0, 2));
            end
            kind = $urandom_range(0, 3);
            send_byte(8'hA5, $urandom_range(0, 2));
            if (kind == 3) begin
                len = $urandom_range(MAX_LEN + 1, 255);
                send_byte(8'(len), $urandom_range(0, 2));
                if (exp_err < 65535) exp_err++;
                chk1("rnd_over_valid", o_frame_valid, 1'b0);
                chk1("rnd_over_busy", o_busy, 1'b0);
            end else begin
                len = $urandom_range(0, MAX_LEN);
                sum = len;
                send_byte(8'(len), $urandom_range(0, 2));
                for (int i = 0; i < len; i++) begin
                    pl[i] = 8'($urandom_range(0, 255));
                    sum += int'(pl[i]);
                    send_byte(pl[i], $urandom_range(0, 2));
                end
                csum = (256 - (sum % 256)) % 256;
                if (kind == 2) csum = (csum + $urandom_range(1, 255)) % 256;
                send_byte(8'(csum), $urandom_range(0, 2));
                if (kind < 2) begin
                    if (exp_count < 65535) exp_count++;
                    pub_len = len;
                    for (int i = 0; i < len; i++) pub_mem[i] = pl[i];
                end else begin
                    if (exp_err < 65535) exp_err++;
                end
                chk1("rnd_valid", o_frame_valid, kind < 2);
                chk1("rnd_busy", o_busy, 1'b0);
            end
            chk8("rnd_len", o_frame_len, 8'(pub_len));
            chk("rnd_count", o_frame_count, 16'(exp_count));
            chk("rnd_err", o_err_count, 16'(exp_err));
            if (pub_len > 0) begin
                idx = $urandom_range(0, pub_len - 1);
                read_chk("rnd_rd", idx, pub_mem[idx]);
            end
        end

        // Reset in the middle of a payload
        send_byte(8'hA5, 0);
        send_byte(8'h05, 0);
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk8("mid_rst_rd_data", o_rd_data, 8'd0);
        chk1("mid_rst_valid", o_frame_valid, 1'b0);
        chk8("mid_rst_len", o_frame_len, 8'd0);
        chk("mid_rst_count", o_frame_count, 16'd0);
        chk("mid_rst_err", o_err_count, 16'd0);
        chk1("mid_rst_busy", o_busy, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        send_byte(8'hA5, 1);
        send_byte(8'h01, 0);
        send_byte(8'h7F, 0);
        send_byte(8'h80, 0);
        chk1("post_rst_valid", o_frame_valid, 1'b1);
        chk8("post_rst_len", o_frame_len, 8'd1);
        chk("post_rst_count", o_frame_count, 16'd1);
        chk("post_rst_err", o_err_count, 16'd0);
        read_chk("post_rst_rd0", 0, 8'h7F);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
